// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store unit between the core and a word-wide data bus
//
// Purpose: turns RV32 loads/stores into one word-aligned bus transfer with byte
// enables, extends load data, stalls the core through wait states, and reports
// misaligned/illegal-size accesses and bus timeouts.
//
// Ports:
//   clk, reset                    clock, synchronous active-low reset
//   req_valid, req_store          access request and direction (1 = store)
//   req_funct3, req_addr          RV32 size/sign code and byte address
//   req_wdata                     store data
//   stall, done, rdata, fault     core-side handshake, extended load data, fault code
//   mem_req, mem_we, mem_addr     registered bus request, write enable, word address
//   mem_be, mem_wdata             registered byte enables and lane-replicated store data
//   mem_ready, mem_rdata          bus completion and read word

module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic [1:0]  fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic [2:0]    f3_q;
   logic [1:0]    off_q;
   logic          store_q;
   logic          timeout_q;
   logic [31:0]   word_q;

   logic          legal, aligned, ok;
   logic [3:0]    be_nx;
   logic [31:0]   wdata_nx;
   logic [7:0]    lane_b;
   logic [15:0]   lane_h;
   logic [31:0]   ext;

   // Size/sign decode; unsigned variants exist only for loads.
   always_comb begin
      legal = 1'b0;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: legal = 1'b1;
         3'b100, 3'b101:         legal = !req_store;
         default:                legal = 1'b0;
      endcase
      aligned = 1'b1;
      case (req_funct3[1:0])
         2'b01:   aligned = !req_addr[0];
         2'b10:   aligned = (req_addr[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
      ok = legal && aligned;
   end

   // Lane placement; enables follow the access size for loads as well.
   always_comb begin
      be_nx    = 4'b1111;
      wdata_nx = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            be_nx    = 4'b0001 << req_addr[1:0];
            wdata_nx = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            be_nx    = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_nx = {2{req_wdata[15:0]}};
         end
         default: begin
            be_nx    = 4'b1111;
            wdata_nx = req_wdata;
         end
      endcase
      if (!req_store) wdata_nx = 32'h0;
   end

   // Load extraction from the captured word.
   always_comb begin
      lane_b = word_q[7:0];
      case (off_q)
         2'b01:   lane_b = word_q[15:8];
         2'b10:   lane_b = word_q[23:16];
         2'b11:   lane_b = word_q[31:24];
         default: lane_b = word_q[7:0];
      endcase
      lane_h = off_q[1] ? word_q[31:16] : word_q[15:0];
      case (f3_q)
         3'b000:  ext = {{24{lane_b[7]}}, lane_b};
         3'b001:  ext = {{16{lane_h[15]}}, lane_h};
         3'b100:  ext = {24'h0, lane_b};
         3'b101:  ext = {16'h0, lane_h};
         default: ext = word_q;
      endcase
   end

   always_comb begin
      state_nx = state;
      stall    = 1'b0;
      done     = 1'b0;
      fault    = 2'b00;
      rdata    = 32'h0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (ok) begin
                  stall    = 1'b1;
                  state_nx = BUS;
               end else begin
                  // Rejected accesses retire immediately without touching the bus.
                  done  = 1'b1;
                  fault = 2'b01;
               end
            end
         end
         BUS: begin
            stall = 1'b1;
            if (mem_ready || cnt == LAST) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            fault    = timeout_q ? 2'b10 : 2'b00;
            rdata    = (store_q || timeout_q) ? 32'h0 : ext;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0;
         mem_be    <= 4'h0;
         mem_wdata <= 32'h0;
         cnt       <= '0;
         f3_q      <= 3'b000;
         off_q     <= 2'b00;
         store_q   <= 1'b0;
         timeout_q <= 1'b0;
         word_q    <= 32'h0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (req_valid && ok) begin
                  mem_req   <= 1'b1;
                  mem_we    <= req_store;
                  mem_addr  <= {req_addr[31:2], 2'b00};
                  mem_be    <= be_nx;
                  mem_wdata <= wdata_nx;
                  f3_q      <= req_funct3;
                  off_q     <= req_addr[1:0];
                  store_q   <= req_store;
                  cnt       <= '0;
                  timeout_q <= 1'b0;
               end
            end
            BUS: begin
               // A response on the last counted cycle still completes normally.
               if (mem_ready) begin
                  word_q  <= mem_rdata;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
               end else if (cnt == LAST) begin
                  word_q    <= 32'h0;
                  timeout_q <= 1'b1;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit

module tb_load_store_unit;

   localparam int T = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        stall, done;
   logic [31:0] rdata;
   logic [1:0]  fault;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   int tests = 0;
   int fails = 0;

   load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_store(req_store), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .done(done), .rdata(rdata), .fault(fault),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One access from request to retire; the bus model answers after 'waits' wait states.
   task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rw, input int waits,
                         output logic [31:0] got);
      bit          legal, ok, tmo;
      int          nbytes, nbus, last;
      logic [31:0] e_be, e_wd, e_rd, lane;
      logic [1:0]  e_fault;
      legal  = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!st && (f3 == 3'd4 || f3 == 3'd5));
      nbytes = 1 << f3[1:0];
      ok     = legal && (a % nbytes == 0);
      e_be   = ((1 << nbytes) - 1) << a[1:0];
      e_wd   = (nbytes == 1) ? {4{wd[7:0]}} : (nbytes == 2) ? {2{wd[15:0]}} : wd;
      tmo    = (waits >= T);
      nbus   = tmo ? T : waits + 1;
      lane   = rw >> (8 * a[1:0]);
      if (nbytes == 4)      e_rd = rw;
      else if (nbytes == 2) e_rd = f3[2] ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      else                  e_rd = f3[2] ? {24'h0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      if (st || tmo) e_rd = 32'h0;
      e_fault = !ok ? 2'b01 : tmo ? 2'b10 : 2'b00;
      last    = ok ? nbus + 1 : 0;
      got     = 32'hx;

      req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
      mem_rdata = rw;
      for (int c = 0; c <= last; c++) begin
         mem_ready = (c >= 1) && (c - 1 == waits);
         @(negedge clk);
         if (c == 0) begin
            chk("stall_first", stall, ok);
            chk("done_first", done, !ok);
            chk("mem_req_first", mem_req, 1'b0);
            if (!ok) begin
               chk("fault_reject", fault, e_fault);
               chk("rdata_reject", rdata, 32'h0);
               got = rdata;
            end
         end else if (c <= nbus) begin
            chk("stall_bus", stall, 1'b1);
            chk("done_bus", done, 1'b0);
            chk("mem_req_bus", mem_req, 1'b1);
            if (c == 1) begin
               chk("mem_addr", mem_addr, {a[31:2], 2'b00});
               chk("mem_we", mem_we, st);
               if (st) begin
                  chk("mem_be", mem_be, e_be);
                  chk("mem_wdata", mem_wdata, e_wd);
               end
            end
         end else begin
            chk("stall_done", stall, 1'b0);
            chk("done_pulse", done, 1'b1);
            chk("mem_req_done", mem_req, 1'b0);
            chk("fault_done", fault, e_fault);
            chk("rdata_done", rdata, e_rd);
            got = rdata;
         end
         @(posedge clk); #1;
      end
      req_valid = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      chk("idle_stall", stall, 1'b0);
      chk("idle_done", done, 1'b0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] got;
      reset = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b010;
      req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_be", mem_be, 4'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_done", done, 1'b0);
      chk("rst_fault", fault, 2'b00);
      chk("rst_stall", stall, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;

      access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, got);
      access(1'b0, 3'b000, 32'h203, 32'h0, 32'h80807F01, 0, got);
      chk("lb_const", got, 32'hFFFFFF80);
      access(1'b0, 3'b100, 32'h203, 32'h0, 32'h80807F01, 1, got);
      chk("lbu_const", got, 32'h00000080);
      access(1'b0, 3'b001, 32'h200, 32'h0, 32'h80807F01, 2, got);
      chk("lh_const", got, 32'h00007F01);
      access(1'b1, 3'b000, 32'h1002, 32'h000000A5, 32'h0, 0, got);
      access(1'b1, 3'b001, 32'h1002, 32'h0000BEEF, 32'h0, 0, got);
      access(1'b0, 3'b010, 32'h101, 32'h0, 32'h12345678, 0, got);
      access(1'b0, 3'b011, 32'h100, 32'h0, 32'h12345678, 0, got);
      access(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0, got);
      access(1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 100, got);
      chk("timeout_rdata", got, 32'h0);
      access(1'b0, 3'b010, 32'h304, 32'h0, 32'hCAFEF00D, T - 1, got);
      chk("last_cycle_ready", got, 32'hCAFEF00D);

      // Reset while the bus is waiting.
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
      mem_ready = 1'b0; mem_rdata = 32'h55AA55AA;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_reset_mem_req", mem_req, 1'b1);
      reset = 1'b0; req_valid = 1'b0;
      @(posedge clk); #1;
      chk("mid_reset_mem_req", mem_req, 1'b0);
      chk("mid_reset_stall", stall, 1'b0);
      chk("mid_reset_done", done, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      access(1'b0, 3'b010, 32'h44, 32'h0, 32'h0BADC0DE, 1, got);
      chk("post_reset_lw", got, 32'h0BADC0DE);

      for (int i = 0; i < 40; i++) begin
         bit          st;
         logic [2:0]  f3;
         logic [31:0] a, wd, rw;
         int          w;
         st = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         wd = $urandom;
         rw = $urandom;
         w  = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3));
         access(st, f3, a, wd, rw, w, got);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
